// File: rtl/task_scheduler_if.sv
// Host task/result handshakes and pipeline issue/retire bus of the task scheduler.
interface task_scheduler_if;
  logic              iRun;
  logic              iTask_valid;
  logic              oTask_ready;
  logic [63:0]       iTask_player;
  logic [63:0]       iTask_opponent;
  logic [14:0]       iTask_tag;
  logic              oRes_valid;
  logic              iRes_ready;
  logic [14:0]       oRes_tag;
  logic signed [7:0] oRes_score;
  logic              oPl_enable;
  logic              oPl_valid;
  logic [63:0]       oPl_player;
  logic [63:0]       oPl_opponent;
  logic [15:0]       oPl_taskid;
  logic              iPl_accept;
  logic              iPl_solved;
  logic [15:0]       iPl_taskid;
  logic signed [7:0] iPl_res;
  logic              oBusy;
  logic              oError;

  // Scheduler side
  modport slave (
    input  iRun, iTask_valid, iTask_player, iTask_opponent, iTask_tag, iRes_ready,
           iPl_accept, iPl_solved, iPl_taskid, iPl_res,
    output oTask_ready, oRes_valid, oRes_tag, oRes_score, oPl_enable, oPl_valid,
           oPl_player, oPl_opponent, oPl_taskid, oBusy, oError
  );

  // Host / pipeline side
  modport master (
    output iRun, iTask_valid, iTask_player, iTask_opponent, iTask_tag, iRes_ready,
           iPl_accept, iPl_solved, iPl_taskid, iPl_res,
    input  oTask_ready, oRes_valid, oRes_tag, oRes_score, oPl_enable, oPl_valid,
           oPl_player, oPl_opponent, oPl_taskid, oBusy, oError
  );
endinterface

// File: rtl/task_scheduler.sv
// Task scheduler: buffers host tasks, issues them to a SLOTS-context pipeline
// under a credit limit, and collects tagged results for the host.
module task_scheduler #(
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned QDEPTH = 4
) (
  input logic             iCLOCK,
  input logic             iRESET_N,
  task_scheduler_if.slave bus
);
  localparam int unsigned CW  = $clog2(SLOTS + 1);
  localparam int unsigned SW  = CW + 1;
  localparam int unsigned QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned QCW = $clog2(QDEPTH + 1);
  localparam int unsigned RAW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef struct packed {
    logic [63:0] player;
    logic [63:0] opponent;
    logic [14:0] tag;
  } task_t;

  typedef struct packed {
    logic [14:0] tag;
    logic [7:0]  score;
  } res_t;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]   outstanding_q;
  logic            pl_enable_q;
  logic            error_q;

  task_t           q_mem [QDEPTH];
  logic [QAW-1:0]  q_wr_q, q_rd_q;
  logic [QCW-1:0]  q_cnt_q;

  res_t            r_mem [SLOTS];
  logic [RAW-1:0]  r_wr_q, r_rd_q;
  logic [CW-1:0]   r_cnt_q;

  logic q_full, q_empty, q_push, q_pop;
  logic r_full, r_valid, r_push, r_pop;
  logic pl_valid_c, pl_fire, ret, ret_ok, ret_err;
  logic flush_entry;

  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (p == QAW'(QDEPTH - 1)) ? '0 : p + QAW'(1);
  endfunction

  function automatic logic [RAW-1:0] r_inc(input logic [RAW-1:0] p);
    return (p == RAW'(SLOTS - 1)) ? '0 : p + RAW'(1);
  endfunction

  // Handshake and credit decode from registered state
  always_comb begin
    q_full      = (q_cnt_q == QCW'(QDEPTH));
    q_empty     = (q_cnt_q == '0);
    r_full      = (r_cnt_q == CW'(SLOTS));
    r_valid     = (r_cnt_q != '0);
    pl_valid_c  = (state_q == S_RUN) && !q_empty &&
                  ((SW'(outstanding_q) + SW'(r_cnt_q)) < SW'(SLOTS));
    q_push      = bus.iTask_valid && !q_full;
    pl_fire     = bus.iPl_accept && pl_valid_c;
    q_pop       = pl_fire;
    r_pop       = r_valid && bus.iRes_ready;
    ret         = bus.iPl_solved && bus.iPl_taskid[15];
    ret_ok      = ret && (outstanding_q != '0);
    r_push      = ret_ok && (!r_full || r_pop);
    ret_err     = ret && ((outstanding_q == '0) || (r_full && !r_pop));
    flush_entry = (state_q == S_IDLE) && (state_d == S_FLUSH);
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iRun) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == CW'(SLOTS - 1)) begin
          state_d     = S_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (!bus.iRun) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.iRun)                    state_d = S_RUN;
        else if (outstanding_q == '0)    state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, flush counter, pipeline enable and sticky error
  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      pl_enable_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pl_enable_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
      if (ret_err) error_q <= 1'b1;
    end
  end

  // Outstanding-task counter; cleared on each new run
  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      outstanding_q <= '0;
    end else if (flush_entry) begin
      outstanding_q <= '0;
    end else if (pl_fire && !ret_ok) begin
      outstanding_q <= outstanding_q + CW'(1);
    end else if (!pl_fire && ret_ok) begin
      outstanding_q <= outstanding_q - CW'(1);
    end
  end

  // Input queue pointers and occupancy
  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
    end else begin
      if (q_push) q_wr_q <= q_inc(q_wr_q);
      if (q_pop)  q_rd_q <= q_inc(q_rd_q);
      q_cnt_q <= q_cnt_q + QCW'(q_push) - QCW'(q_pop);
    end
  end

  // Input queue storage
  always_ff @(posedge iCLOCK) begin
    if (q_push) q_mem[q_wr_q] <= '{player:   bus.iTask_player,
                                   opponent: bus.iTask_opponent,
                                   tag:      bus.iTask_tag};
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_wr_q  <= '0;
      r_rd_q  <= '0;
      r_cnt_q <= '0;
    end else begin
      if (r_push) r_wr_q <= r_inc(r_wr_q);
      if (r_pop)  r_rd_q <= r_inc(r_rd_q);
      r_cnt_q <= r_cnt_q + CW'(r_push) - CW'(r_pop);
    end
  end

  // Result FIFO storage
  always_ff @(posedge iCLOCK) begin
    if (r_push) r_mem[r_wr_q] <= '{tag: bus.iPl_taskid[14:0], score: bus.iPl_res};
  end

  assign bus.oTask_ready  = !q_full;
  assign bus.oPl_enable   = pl_enable_q;
  assign bus.oPl_valid    = pl_valid_c;
  assign bus.oPl_player   = pl_valid_c ? q_mem[q_rd_q].player   : '0;
  assign bus.oPl_opponent = pl_valid_c ? q_mem[q_rd_q].opponent : '0;
  assign bus.oPl_taskid   = pl_valid_c ? {1'b1, q_mem[q_rd_q].tag} : '0;
  assign bus.oRes_valid   = r_valid;
  assign bus.oRes_tag     = r_valid ? r_mem[r_rd_q].tag : '0;
  assign bus.oRes_score   = r_valid ? r_mem[r_rd_q].score : '0;
  assign bus.oBusy        = (state_q != S_IDLE);
  assign bus.oError       = error_q;
endmodule
